// File: rtl/topk_result_serializer_pkg.sv
// Shared types and helpers for the top-K result serializer: read-side state encoding,
// index-width sizing and the rank-to-element mapping used by the sorting network.
package topk_result_serializer_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // m_index needs at least one bit even when only a single element is emitted.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Position of the element with the given rank inside a sorted vector of n elements.
    function automatic int best_elem(input int n, input int rank, input bit asc);
        return asc ? (n - 1 - rank) : rank;
    endfunction

endpackage

// File: rtl/topk_result_serializer_vec_buffer.sv
// Two-slot ping-pong store for sorted vectors; the caller only writes when not full
// and only retires the slot at rd_ptr, so the slot being read is never overwritten.
module topk_result_serializer_vec_buffer #(
    parameter int VEC_W = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [VEC_W-1:0] wr_data_i,
    input  logic             rd_done_i,
    output logic [VEC_W-1:0] rd_data_o,
    output logic [1:0]       count_o,
    output logic             full_o
);

    logic [VEC_W-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    // A write and a retire in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (wr_en_i && !rd_done_i) begin
            count_d = count_q + 2'd1;
        end else if (!wr_en_i && rd_done_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (wr_en_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (rd_done_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            slot_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = slot_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == 2'd2);

endmodule

// File: rtl/topk_result_serializer.sv
// Consumer end of the bitonic sorter: buffers sorted vectors and streams the best K
// elements one per valid/ready beat, counting vectors lost to overrun.
module topk_result_serializer
    import topk_result_serializer_pkg::*;
#(
    parameter int  LOG_INPUT_NUM = 4,
    parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int  K             = 8,
    parameter bit  ASCENDING     = 1'b1,
    localparam int N             = 2 ** LOG_INPUT_NUM,
    localparam int IDX_W         = idx_width(K)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH*N-1:0] x,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [IDX_W-1:0]        m_index,
    output logic                    m_last,
    output logic                    drop_err,
    output logic [15:0]             drop_cnt
);

    rd_state_e                state_q;
    logic [IDX_W-1:0]         rank_q;
    logic                     drop_err_q;
    logic [15:0]              drop_cnt_q;

    logic [DATA_WIDTH*N-1:0]  rd_vec;
    logic [DATA_WIDTH-1:0]    elem [N];
    logic [LOG_INPUT_NUM-1:0] sel;
    logic [1:0]               count;
    logic                     full;
    logic                     wr_en;
    logic                     drop;
    logic                     beat;
    logic                     rank_last;
    logic                     retire;

    // Fullness is judged on the registered count, so a same-cycle retire cannot rescue a vector.
    assign wr_en     = i_valid && !full;
    assign drop      = i_valid && full;
    assign rank_last = (rank_q == IDX_W'(K - 1));
    assign beat      = (state_q == RD_STREAM) && m_ready;
    assign retire    = beat && rank_last;

    topk_result_serializer_vec_buffer #(
        .VEC_W(DATA_WIDTH * N)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (x),
        .rd_done_i (retire),
        .rd_data_o (rd_vec),
        .count_o   (count),
        .full_o    (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RD_IDLE;
            rank_q  <= '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (wr_en) begin
                        state_q <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (beat) begin
                        if (rank_last) begin
                            rank_q <= '0;
                            if (count == 2'd1 && !wr_en) begin
                                state_q <= RD_IDLE;
                            end
                        end else begin
                            rank_q <= rank_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            drop_err_q <= drop;
            if (drop && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_elem
        assign elem[g] = rd_vec[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel = LOG_INPUT_NUM'(best_elem(N, int'(rank_q), ASCENDING));

    // Data-path outputs are forced to zero while idle so stale slot contents never leak out.
    assign m_valid  = (state_q == RD_STREAM);
    assign m_data   = m_valid ? elem[sel] : '0;
    assign m_index  = m_valid ? rank_q : '0;
    assign m_last   = m_valid && rank_last;
    assign in_ready = !full;
    assign drop_err = drop_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_topk_result_serializer.sv
// Scoreboard bench for topk_result_serializer: a default instance (N=16, K=8, ascending)
// and a K=1 descending instance, checked against a queue-based reference model.
module tb_topk_result_serializer;

    localparam int LOG = 4;
    localparam int N   = 16;
    localparam int DW  = 32;
    localparam int VW  = DW * N;
    localparam int K   = 8;
    localparam int K2  = 1;

    typedef struct {
        logic [DW-1:0] d;
        int            idx;
        bit            last;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          i_valid, i_valid2;
    logic [VW-1:0] x, x2;
    logic          in_ready, in_ready2;
    logic [DW-1:0] m_data, m_data2;
    logic          m_valid, m_valid2;
    logic          m_ready, m_ready2;
    logic [2:0]    m_index;
    logic [0:0]    m_index2;
    logic          m_last, m_last2;
    logic          drop_err, drop_err2;
    logic [15:0]   drop_cnt, drop_cnt2;

    int total = 0;
    int bad   = 0;

    beat_t expq[$];
    beat_t expq2[$];
    int pushed = 0, retired = 0, exp_drops = 0, obs_drops = 0;
    int pushed2 = 0, retired2 = 0, exp_drops2 = 0, obs_drops2 = 0;

    topk_result_serializer #(
        .LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .K(K), .ASCENDING(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .x(x), .in_ready(in_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index),
        .m_last(m_last), .drop_err(drop_err), .drop_cnt(drop_cnt)
    );

    topk_result_serializer #(
        .LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .K(K2), .ASCENDING(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .i_valid(i_valid2), .x(x2), .in_ready(in_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2), .m_index(m_index2),
        .m_last(m_last2), .drop_err(drop_err2), .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Vector with element i at bits [DW*(i+1)-1 : DW*i]; mode 0 gives base+i, otherwise random.
    function automatic logic [VW-1:0] mkvec(input int mode, input int base);
        logic [VW-1:0] v;
        v = '0;
        for (int i = N - 1; i >= 0; i--) begin
            v = {v[VW-DW-1:0], (mode == 0) ? DW'(base + i) : DW'($urandom)};
        end
        return v;
    endfunction

    // Reference: list elements best-first (ascending sort puts the best last), keep the first k.
    task automatic push_beats(input logic [VW-1:0] v, input int k, input bit asc, input int which);
        logic [DW-1:0] order[$];
        logic [VW-1:0] t;
        beat_t         b;
        for (int i = 0; i < N; i++) begin
            t = v >> (i * DW);
            if (asc) order.push_front(t[DW-1:0]);
            else     order.push_back(t[DW-1:0]);
        end
        for (int r = 0; r < k; r++) begin
            b.d    = order[r];
            b.idx  = r;
            b.last = (r == k - 1);
            if (which == 0) expq.push_back(b);
            else            expq2.push_back(b);
        end
    endtask

    task automatic send(input logic [VW-1:0] v);
        int occ;
        occ = pushed - retired;
        chk("in_ready", 64'(in_ready), 64'(occ < 2));
        if (occ < 2) begin
            push_beats(v, K, 1'b1, 0);
            pushed++;
        end else begin
            exp_drops++;
        end
        x       = v;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send2(input logic [VW-1:0] v);
        int occ;
        occ = pushed2 - retired2;
        chk("in_ready2", 64'(in_ready2), 64'(occ < 2));
        if (occ < 2) begin
            push_beats(v, K2, 1'b0, 1);
            pushed2++;
        end else begin
            exp_drops2++;
        end
        x2       = v;
        i_valid2 = 1'b1;
        @(posedge clk);
        #1;
        i_valid2 = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget   = 0;
        m_ready  = 1'b1;
        m_ready2 = 1'b1;
        while ((expq.size() != 0 || expq2.size() != 0) && budget < 2000) begin
            cyc(1);
            budget++;
        end
        chk("drain_pending", 64'(expq.size() + expq2.size()), 64'(0));
        cyc(1);
        chk("drain_idle", 64'(m_valid | m_valid2), 64'(0));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (drop_err) obs_drops++;
            if (m_valid) begin
                if (expq.size() == 0) begin
                    chk("beat_expected", 64'(expq.size()), 64'(1));
                end else begin
                    chk("m_data", 64'(m_data), 64'(expq[0].d));
                    chk("m_index", 64'(m_index), 64'(expq[0].idx));
                    chk("m_last", 64'(m_last), 64'(expq[0].last));
                    if (m_ready) begin
                        if (expq[0].last) retired++;
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (drop_err2) obs_drops2++;
            if (m_valid2) begin
                if (expq2.size() == 0) begin
                    chk("beat_expected2", 64'(expq2.size()), 64'(1));
                end else begin
                    chk("m_data2", 64'(m_data2), 64'(expq2[0].d));
                    chk("m_index2", 64'(m_index2), 64'(expq2[0].idx));
                    chk("m_last2", 64'(m_last2), 64'(expq2[0].last));
                    if (m_ready2) begin
                        if (expq2[0].last) retired2++;
                        void'(expq2.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_valid2 = 1'b0;
        x        = '0;
        x2       = '0;
        m_ready  = 1'b0;
        m_ready2 = 1'b0;
        cyc(3);
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_m_index", 64'(m_index), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_drop_err", 64'(drop_err), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;
        cyc(2);
        chk("post_rst_m_valid", 64'(m_valid | m_valid2), 64'(0));

        // Single vector x[i]=i, ready held high: K consecutive beats starting next cycle.
        m_ready = 1'b1;
        send(mkvec(0, 0));
        chk("t1_first_beat", 64'(m_valid), 64'(1));
        chk("t1_first_data", 64'(m_data), 64'(15));
        cyc(7);
        chk("t1_last_beat", 64'(m_last), 64'(1));
        chk("t1_last_data", 64'(m_data), 64'(8));
        cyc(1);
        chk("t1_idle", 64'(m_valid), 64'(0));

        // Same vector with ready toggling 1,0,1,0: exactly 16 cycles to empty.
        send(mkvec(0, 0));
        for (int c = 0; c < 16; c++) begin
            m_ready = (c % 2 == 0);
            cyc(1);
        end
        chk("t2_drained", 64'(expq.size()), 64'(0));
        chk("t2_idle", 64'(m_valid), 64'(0));

        // Three back-to-back pulses while stalled: third is dropped.
        m_ready = 1'b0;
        send(mkvec(1, 0));
        send(mkvec(1, 0));
        send(mkvec(1, 0));
        chk("t3_drop_err", 64'(drop_err), 64'(1));
        chk("t3_drop_cnt", 64'(drop_cnt), 64'(1));
        cyc(1);
        chk("t3_drop_err_pulse", 64'(drop_err), 64'(0));
        drain();

        // Full buffer, pulse coincides with the m_last handshake: still dropped, one slot left.
        m_ready = 1'b0;
        send(mkvec(1, 0));
        send(mkvec(1, 0));
        m_ready = 1'b1;
        cyc(7);
        send(mkvec(1, 0));
        chk("t4_drop_cnt", 64'(drop_cnt), 64'(2));
        chk("t4_in_ready", 64'(in_ready), 64'(1));
        drain();

        // Randomized traffic with random backpressure.
        for (int it = 0; it < 300; it++) begin
            m_ready = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) send(mkvec(1, 0));
            else cyc(1);
        end
        drain();
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        chk("rand_drop_pulses", 64'(obs_drops), 64'(exp_drops));

        // Descending, K=1 instance: single best beat, then random traffic.
        m_ready2 = 1'b1;
        send2(mkvec(0, 100));
        chk("t5_valid", 64'(m_valid2), 64'(1));
        chk("t5_data", 64'(m_data2), 64'(100));
        chk("t5_last", 64'(m_last2), 64'(1));
        cyc(1);
        chk("t5_idle", 64'(m_valid2), 64'(0));
        for (int it = 0; it < 80; it++) begin
            m_ready2 = ($urandom_range(2) == 0);
            if ($urandom_range(1) == 0) send2(mkvec(1, 0));
            else cyc(1);
        end
        drain();
        chk("t5_drop_cnt", 64'(drop_cnt2), 64'(exp_drops2));
        chk("t5_drop_pulses", 64'(obs_drops2), 64'(exp_drops2));

        // Reset mid-stream with a second vector queued: everything is discarded.
        m_ready = 1'b0;
        send(mkvec(1, 0));
        send(mkvec(1, 0));
        m_ready = 1'b1;
        cyc(4);
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", 64'(m_valid), 64'(0));
        chk("t6_last_drop", 64'(m_last), 64'(0));
        expq.delete();
        expq2.delete();
        pushed = 0; retired = 0; exp_drops = 0; obs_drops = 0;
        pushed2 = 0; retired2 = 0; exp_drops2 = 0; obs_drops2 = 0;
        cyc(2);
        rst = 1'b0;
        cyc(20);
        chk("t6_no_beats", 64'(m_valid), 64'(0));
        chk("t6_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("t6_in_ready", 64'(in_ready), 64'(1));
        send(mkvec(0, 7));
        chk("t6_restart", 64'(m_data), 64'(22));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
